spi_cmd_sequencer: RTL and testbench

- Command controller between the SPI byte receiver and the 8-bit PMOD output.
- Consumes the byte stream the receiver produces (already synchronized into the system clock domain, one-cycle valid strobe per byte).
- Parses bytes into fixed-length command frames, executes them against a small register file, and drives the selected register onto the display output.
- The SPI link has no chip-select, so an idle timeout delimits frames.

---
 rtl/spi_cmd_sequencer_pkg.sv | 26 ++
 rtl/spi_cmd_sequencer_if.sv | 21 ++
 rtl/spi_cmd_sequencer_regfile.sv | 33 +++
 rtl/spi_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// rtl/spi_cmd_sequencer_pkg.sv - shared opcodes, state/mode enums and helpers
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_SELECT = 8'h02;
  localparam logic [7:0] OP_CLEAR  = 8'h03;

  localparam int ERR_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  typedef enum logic {
    WRITE  = 1'b0,
    SELECT = 1'b1
  } mode_t;

  // Error counter increments but sticks at all-ones
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// rtl/spi_cmd_sequencer_if.sv - byte stream in, display/status out
import spi_cmd_pkg::*;

interface spi_cmd_sequencer_if;
  logic             _i_byte_valid;
  logic [7:0]       _i_byte;
  logic [7:0]       o_display;
  logic             o_busy;
  logic [ERR_W-1:0] o_err_count;
  logic             o_frame_done;

  modport master (
    output _i_byte_valid, _i_byte,
    input  o_display, o_busy, o_err_count, o_frame_done
  );

  modport slave (
    input  _i_byte_valid, _i_byte,
    output o_display, o_busy, o_err_count, o_frame_done
  );
endinterface

// File: rtl/spi_cmd_sequencer_regfile.sv
// rtl/spi_cmd_sequencer_regfile.sv - register storage with clear and registered display mux
module spi_cmd_regfile #(
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          clr,
  input  logic [AW-1:0] sel,
  output logic [7:0]    display
);

  logic [7:0] regs [NUM_REGS];

  // Storage: reset and CLEAR both zero every register; otherwise single write port
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Output register: display follows regs[sel] one cycle behind any update
  always_ff @(posedge clk) begin
    if (rst) display <= '0;
    else     display <= regs[sel];
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - frame parser, idle timeout and command execution
import spi_cmd_pkg::*;

module spi_cmd_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                _i_clk,
  input  logic                _i_rst,
  spi_cmd_sequencer_if.slave  bus
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t           state_q, state_n;
  mode_t            mode_q, mode_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic [AW-1:0]    sel_q, sel_n;
  logic [TW-1:0]    timer_q, timer_n;
  logic [ERR_W-1:0] err_q, err_n;
  logic             done_q, done_n;
  logic             we, clr;

  // State register; a strobe in the reset cycle is dropped because reset wins
  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      state_q <= IDLE;
      mode_q  <= WRITE;
      addr_q  <= '0;
      sel_q   <= '0;
      timer_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      addr_q  <= addr_n;
      sel_q   <= sel_n;
      timer_q <= timer_n;
      err_q   <= err_n;
      done_q  <= done_n;
    end
  end

  // Next-state: parse bytes, execute on the final byte, abandon stalled frames
  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    addr_n  = addr_q;
    sel_n   = sel_q;
    timer_n = '0;
    err_n   = err_q;
    done_n  = 1'b0;
    we      = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus._i_byte_valid) begin
          case (bus._i_byte)
            OP_WRITE: begin
              state_n = WAIT_ADDR;
              mode_n  = WRITE;
            end
            OP_SELECT: begin
              state_n = WAIT_ADDR;
              mode_n  = SELECT;
            end
            OP_CLEAR: begin
              clr    = 1'b1;
              done_n = 1'b1;
            end
            default: err_n = sat_inc(err_q);
          endcase
        end
      end
      WAIT_ADDR: begin
        if (bus._i_byte_valid) begin
          addr_n = bus._i_byte[AW-1:0];
          if (mode_q == WRITE) begin
            state_n = WAIT_DATA;
          end else begin
            sel_n   = bus._i_byte[AW-1:0];
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else if (timer_q == TMAX) begin
          state_n = IDLE;
          err_n   = sat_inc(err_q);
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end
      WAIT_DATA: begin
        if (bus._i_byte_valid) begin
          we      = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (timer_q == TMAX) begin
          state_n = IDLE;
          err_n   = sat_inc(err_q);
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  spi_cmd_regfile #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_regfile (
    .clk     (_i_clk),
    .rst     (_i_rst),
    .we      (we),
    .waddr   (addr_q),
    .wdata   (bus._i_byte),
    .clr     (clr),
    .sel     (sel_q),
    .display (bus.o_display)
  );

  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_err_count  = err_q;
  assign bus.o_frame_done = done_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - directed self-checking bench for spi_cmd_sequencer
module tb_spi_cmd_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   d0;

  spi_cmd_sequencer_if bus ();

  spi_cmd_sequencer #(
    .NUM_REGS (4),
    .TIMEOUT  (16)
  ) dut (
    ._i_clk (clk),
    ._i_rst (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses, sampled mid-cycle
  always @(negedge clk) if (bus.o_frame_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] b);
    bus._i_byte_valid = 1'b1;
    bus._i_byte       = b;
    @(negedge clk);
    bus._i_byte_valid = 1'b0;
  endtask

  // Reset with a bad-opcode strobe held during it, which must be ignored
  task automatic do_reset();
    rst = 1'b1;
    bus._i_byte_valid = 1'b1;
    bus._i_byte       = 8'h7F;
    tick(2);
    bus._i_byte_valid = 1'b0;
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus._i_byte_valid = 1'b0;
    bus._i_byte       = 8'h00;
    @(negedge clk);
    do_reset();
    check("rst_display", bus.o_display, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_err", bus.o_err_count, 0);
    check("rst_done", bus.o_frame_done, 0);

    // Write reg2 = A5, then select reg2, one-cycle gaps
    done_cnt = 0;
    strobe(8'h01); tick(1); strobe(8'h02); tick(1); strobe(8'hA5);
    check("wr_done_pulse", bus.o_frame_done, 1);
    tick(1);
    strobe(8'h02); tick(1); strobe(8'h02);
    check("sel_latency", bus.o_display, 0);
    tick(1);
    check("sel_display", bus.o_display, 8'hA5);
    check("t1_done_cnt", done_cnt, 2);
    check("t1_err", bus.o_err_count, 0);

    // Back-to-back frames with no idle cycles
    strobe(8'h01); strobe(8'h00); strobe(8'h11);
    strobe(8'h01); strobe(8'h01); strobe(8'h22);
    strobe(8'h02); strobe(8'h01);
    tick(1);
    check("b2b_display_r1", bus.o_display, 8'h22);
    strobe(8'h02); strobe(8'h00);
    tick(1);
    check("b2b_display_r0", bus.o_display, 8'h11);
    check("b2b_busy", bus.o_busy, 0);

    // Bad opcodes in IDLE
    d0 = done_cnt;
    strobe(8'h7F);
    check("badop_busy", bus.o_busy, 0);
    strobe(8'hFF);
    tick(2);
    check("badop_err", bus.o_err_count, 2);
    check("badop_busy2", bus.o_busy, 0);
    check("badop_no_done", done_cnt, d0);

    // Timeout discards a partial WRITE
    do_reset();
    strobe(8'h01); strobe(8'h00); strobe(8'h44);
    tick(1);
    check("to_pre_display", bus.o_display, 8'h44);
    strobe(8'h01); strobe(8'h03);
    check("to_busy_start", bus.o_busy, 1);
    tick(15);
    check("to_busy_before", bus.o_busy, 1);
    tick(1);
    check("to_busy_after", bus.o_busy, 0);
    check("to_err", bus.o_err_count, 1);
    strobe(8'h02); strobe(8'h03);
    tick(1);
    check("to_reg3_unwritten", bus.o_display, 0);

    // Strobe lands on the timeout cycle and wins
    do_reset();
    strobe(8'h01);
    tick(15);
    check("edge_busy", bus.o_busy, 1);
    strobe(8'h03); strobe(8'h5A);
    strobe(8'h02); strobe(8'h03);
    tick(1);
    check("edge_reg3", bus.o_display, 8'h5A);
    check("edge_err", bus.o_err_count, 0);

    // Write to the selected register, then CLEAR
    strobe(8'h01); strobe(8'h01); strobe(8'h33);
    strobe(8'h02); strobe(8'h01);
    tick(1);
    check("sel1_display", bus.o_display, 8'h33);
    strobe(8'h01); strobe(8'h01); strobe(8'h44);
    check("wsel_latency", bus.o_display, 8'h33);
    tick(1);
    check("wsel_display", bus.o_display, 8'h44);
    strobe(8'h03);
    check("clr_latency", bus.o_display, 8'h44);
    check("clr_done", bus.o_frame_done, 1);
    tick(1);
    check("clr_display", bus.o_display, 0);

    // Reset mid-WRITE discards the frame silently
    strobe(8'h01); strobe(8'h00);
    do_reset();
    check("midrst_busy", bus.o_busy, 0);
    strobe(8'h02); strobe(8'h00);
    tick(1);
    check("midrst_display", bus.o_display, 0);
    check("midrst_err", bus.o_err_count, 0);

    // Error counter saturation
    for (int i = 0; i < 16; i++) strobe(8'hFF);
    tick(1);
    check("err_sat", bus.o_err_count, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
